// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end and IF/ID pipeline register.
// Fetches over a single-outstanding req/ack port and keeps a one-entry skid
// buffer for words that arrive while decode stalls. When no instruction is
// ready it inserts NOP bubbles. Branch redirects are applied once the
// delay-slot word is in hand.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        next_inst_in_delayslot_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        is_in_delayslot_o
);

    typedef enum logic {IDLE, FETCH} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        ds_pending_q, ds_pending_d;
    logic        redir_pending_q, redir_pending_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic        ds_out_q, ds_out_d;

    logic ack;
    logic br_acc;
    logic word_avail;
    logic ds_eff;

    // Request is suppressed while a skid word is parked and in the reset cycle
    assign imem_req_o  = (state_q == FETCH) & ~hold_valid_q & ~rst;
    assign imem_addr_o = pc_q;
    assign ack         = imem_ack_i & imem_req_o;
    assign br_acc      = branch_flag_i & ifid_valid_q & ~stall_i;
    // Delay-slot word is either parked in the skid buffer or arriving now
    assign word_avail  = hold_valid_q | ack;
    // A branch accepted this cycle marks the word loaded alongside it
    assign ds_eff      = br_acc ? next_inst_in_delayslot_i : ds_pending_q;

    assign pc_o              = pc_out_q;
    assign inst_o            = inst_out_q;
    assign is_in_delayslot_o = ds_out_q;

    // Next-state: fetch pointer, skid buffer, IF/ID load and redirect tracking
    always_comb begin
        state_d         = FETCH;
        pc_d            = pc_q;
        hold_valid_d    = hold_valid_q;
        hold_inst_d     = hold_inst_q;
        hold_pc_d       = hold_pc_q;
        ifid_valid_d    = ifid_valid_q;
        ds_pending_d    = ds_pending_q;
        redir_pending_d = redir_pending_q;
        redir_target_d  = redir_target_q;
        pc_out_d        = pc_out_q;
        inst_out_d      = inst_out_q;
        ds_out_d        = ds_out_q;

        if (ack) begin
            pc_d            = redir_pending_q ? redir_target_q : pc_q + 32'd4;
            redir_pending_d = 1'b0;
        end

        if (stall_i) begin
            if (ack) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = imem_rdata_i;
                hold_pc_d    = pc_q;
            end
        end else begin
            if (word_avail) begin
                pc_out_d     = hold_valid_q ? hold_pc_q : pc_q;
                inst_out_d   = hold_valid_q ? hold_inst_q : imem_rdata_i;
                ds_out_d     = ds_eff;
                ifid_valid_d = 1'b1;
                ds_pending_d = 1'b0;
                hold_valid_d = 1'b0;
            end else begin
                inst_out_d   = NOP_INST;
                ds_out_d     = 1'b0;
                ifid_valid_d = 1'b0;
                ds_pending_d = ds_eff;
            end
            if (br_acc) begin
                if (word_avail) begin
                    pc_d = branch_target_address_i;
                end else begin
                    redir_pending_d = 1'b1;
                    redir_target_d  = branch_target_address_i;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            hold_valid_q    <= 1'b0;
            hold_inst_q     <= NOP_INST;
            hold_pc_q       <= 32'h0;
            ifid_valid_q    <= 1'b0;
            ds_pending_q    <= 1'b0;
            redir_pending_q <= 1'b0;
            redir_target_q  <= 32'h0;
            pc_out_q        <= 32'h0;
            inst_out_q      <= NOP_INST;
            ds_out_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            hold_valid_q    <= hold_valid_d;
            hold_inst_q     <= hold_inst_d;
            hold_pc_q       <= hold_pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ds_pending_q    <= ds_pending_d;
            redir_pending_q <= redir_pending_d;
            redir_target_q  <= redir_target_d;
            pc_out_q        <= pc_out_d;
            inst_out_q      <= inst_out_d;
            ds_out_q        <= ds_out_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory responder, queue-based
// reference model of the instruction stream, and directed literal checks.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] MAGIC    = 32'hC0DE_0001;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        nds;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        ds_o;

    int n_checks = 0;
    int n_errors = 0;
    int phase    = 0;
    int cyc      = 0;
    int lat_fix  = 0;
    int lat_rand = 0;
    int lat_cur  = 0;
    int wait_cnt = 0;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .stall_i                  (stall),
        .branch_flag_i            (br),
        .branch_target_address_i  (tgt),
        .next_inst_in_delayslot_i (nds),
        .imem_req_o               (imem_req),
        .imem_addr_o              (imem_addr),
        .imem_ack_i               (imem_ack),
        .imem_rdata_i             (imem_rdata),
        .pc_o                     (pc_o),
        .inst_o                   (inst_o),
        .is_in_delayslot_o        (ds_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word is address ^ MAGIC (never a NOP); ack after lat_cur waits
    assign imem_rdata = imem_addr ^ MAGIC;
    assign imem_ack   = imem_req && (wait_cnt >= lat_cur);

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
            lat_cur  <= (lat_rand != 0) ? int'($urandom_range(0, 3)) : lat_fix;
        end else if (imem_req && imem_ack) begin
            wait_cnt <= 0;
            lat_cur  <= (lat_rand != 0) ? int'($urandom_range(0, 3)) : lat_fix;
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (phase %0d cyc %0d)", nm, act, exp, phase, cyc);
        end
    endtask

    // Reference model: acked words queue up in order; each non-stalled cycle
    // decode takes the oldest one or a bubble. A taken branch sends the fetch
    // after its delay slot to the target.
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] m_pc, m_inst, m_next, m_tgt;
    logic        m_ds, m_valid, m_dspend, m_redir, m_run;
    logic        m_br, m_dse;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'd0);
            qa.delete();
            qd.delete();
            m_pc = 32'h0; m_inst = NOP_INST; m_ds = 1'b0; m_valid = 1'b0;
            m_dspend = 1'b0; m_next = RESET_PC; m_redir = 1'b0; m_tgt = 32'h0;
            m_run = 1'b0;
            cyc = 0;
        end else begin
            chk("pc_o", pc_o, m_pc);
            chk("inst_o", inst_o, m_inst);
            chk("ds_o", {31'b0, ds_o}, {31'b0, m_ds});
            chk("req", {31'b0, imem_req}, {31'b0, (m_run && qa.size() == 0)});
            chk("addr", imem_addr, m_next);

            if (phase == 1) begin
                case (cyc)
                    0: chk("lit_idle_req", {31'b0, imem_req}, 32'd0);
                    1: begin chk("lit_first_req", {31'b0, imem_req}, 32'd1);
                             chk("lit_first_addr", imem_addr, 32'h0); end
                    2: begin chk("lit_pc0", pc_o, 32'h0); chk("lit_ds0", {31'b0, ds_o}, 32'd0); end
                    3: chk("lit_pc4", pc_o, 32'h4);
                    4: begin chk("lit_pc8", pc_o, 32'h8); chk("lit_inst8", inst_o, 32'h8 ^ MAGIC); end
                    6: begin chk("lit_br_pc", pc_o, 32'h10); chk("lit_ds_addr", imem_addr, 32'h14);
                             chk("lit_ds_ack", {31'b0, imem_ack}, 32'd1); end
                    7: begin chk("lit_ds_pc", pc_o, 32'h14); chk("lit_ds_flag", {31'b0, ds_o}, 32'd1);
                             chk("lit_tgt_addr", imem_addr, 32'h100); end
                    8: begin chk("lit_tgt_pc", pc_o, 32'h100); chk("lit_tgt_ds", {31'b0, ds_o}, 32'd0); end
                    default: ;
                endcase
            end else if (phase == 2) begin
                case (cyc)
                    2: begin chk("lit_wait_addr", imem_addr, 32'h0); chk("lit_wait_ack", {31'b0, imem_ack}, 32'd0); end
                    4: chk("lit_l3_pc0", pc_o, 32'h0);
                    5: begin chk("lit_bubble_inst", inst_o, NOP_INST); chk("lit_bubble_pc", pc_o, 32'h0); end
                    7: chk("lit_l3_pc4", pc_o, 32'h4);
                    default: ;
                endcase
            end

            // Advance the model with the inputs the DUT samples at the next edge
            if (imem_ack) begin
                qa.push_back(imem_addr);
                qd.push_back(imem_rdata);
                m_next  = m_redir ? m_tgt : imem_addr + 32'd4;
                m_redir = 1'b0;
            end
            if (!stall) begin
                m_br  = br && m_valid;
                m_dse = m_br ? nds : m_dspend;
                if (qa.size() > 0) begin
                    m_pc     = qa.pop_front();
                    m_inst   = qd.pop_front();
                    m_ds     = m_dse;
                    m_valid  = 1'b1;
                    m_dspend = 1'b0;
                    if (m_br) m_next = tgt;
                end else begin
                    m_inst   = NOP_INST;
                    m_ds     = 1'b0;
                    m_valid  = 1'b0;
                    m_dspend = m_dse;
                    if (m_br) begin
                        m_redir = 1'b1;
                        m_tgt   = tgt;
                    end
                end
            end
            m_run = 1'b1;
            cyc++;
        end
    end

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br = 1'b0; nds = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; nds = 1'b0;

        // Zero-wait memory, branch at 0x10 with its delay slot acked alongside
        phase = 1; lat_fix = 0; lat_rand = 0;
        do_reset();
        repeat (6) @(posedge clk);
        #1; br = 1'b1; tgt = 32'h100; nds = 1'b1;
        @(posedge clk); #1; br = 1'b0; nds = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Three-cycle memory latency
        phase = 2; lat_fix = 2;
        do_reset();
        repeat (10) @(posedge clk);
        #1;

        // Random latency, stalls, branches and occasional mid-flight resets
        phase = 3; lat_rand = 1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 5) == 0);
            nds   = ($urandom_range(0, 4) != 0);
            tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        end
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0; br = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
